// File: rtl/wrselb_pkg.sv
// wrselb_pkg: shared store-size, state and byte-enable encodings for the write-select buffer
package wrselb_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [3:0] BE_FULL = 4'hF;
  typedef enum logic [1:0] {EMPTY, HOLD, DRAIN} state_t;
endpackage

// File: rtl/wrselb_lane.sv
// wrselb_lane: combinational store lane placement (size, addr[1:0], data -> placed data, be, misalign)
// ports: size/addr/data in; lane_data, be (zero when misaligned), misalign out
// macro WRSELB_WCB_BIG_ENDIAN_EN selects the big-endian lane mapping
module wrselb_lane
  import wrselb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] lane_data,
  output logic [3:0]  be,
  output logic        misalign
);
  logic [31:0] word;
  logic [3:0] be_byte, be_half;
`ifdef WRSELB_WCB_BIG_ENDIAN_EN
  assign word = {data[7:0], data[15:8], data[23:16], data[31:24]};
  assign be_byte = 4'b1000 >> addr;
  assign be_half = addr[1] ? 4'b0011 : 4'b1100;
`else
  assign word = data;
  assign be_byte = 4'b0001 << addr;
  assign be_half = addr[1] ? 4'b1100 : 4'b0011;
`endif
  assign lane_data = size == SIZE_BYTE ? {4{data[7:0]}} : size == SIZE_HALF ? {2{data[15:0]}} : word;
  assign misalign = size == SIZE_BYTE ? 1'b0 : size == SIZE_HALF ? addr[0] : size == SIZE_WORD ? |addr : 1'b1;
  assign be = misalign ? 4'b0000 : size == SIZE_BYTE ? be_byte : size == SIZE_HALF ? be_half : BE_FULL;
endmodule

// File: rtl/wrselb_wcb.sv
// wrselb_wcb: byte write-select with a single-entry write-combining buffer issuing aligned word writes
// ports: clk, srst_n (sync active-low); in_valid/in_ready/in_addr/in_size/in_data store side;
//        flush drains HOLD; out_valid/out_ready/out_addr/out_data/out_be memory side; misalign_err pulse
// macro WRSELB_WCB_BIG_ENDIAN_EN selects the big-endian lane mapping (in wrselb_lane)
module wrselb_wcb
  import wrselb_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int TIMEOUT = 8,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  srst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH+1:0] in_addr,
  input  logic [1:0]            in_size,
  input  logic [31:0]           in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [31:0]           out_data,
  output logic [3:0]            out_be,
  output logic                  misalign_err
);
  state_t state, state_nx;
  logic [TIMEOUT_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] in_word;
  logic [31:0] ln_data, mask;
  logic [3:0] ln_be;
  logic ln_mis, same, accept, timeout;
  wrselb_lane u_lane (
    .size(in_size),
    .addr(in_addr[1:0]),
    .data(in_data),
    .lane_data(ln_data),
    .be(ln_be),
    .misalign(ln_mis)
  );
  assign in_word = in_addr[ADDR_WIDTH+1:2];
  assign same = in_word == out_addr;
  assign mask = {{8{ln_be[3]}}, {8{ln_be[2]}}, {8{ln_be[1]}}, {8{ln_be[0]}}};
  assign timeout = cnt == TIMEOUT_WIDTH'(TIMEOUT - 1);
  assign out_valid = state == DRAIN;
  assign in_ready = state == EMPTY || (state == HOLD && (same || ln_mis));
  assign accept = in_valid && in_ready && !ln_mis;
  // a different-word store stalls in HOLD and forces the drain; misaligned ones are swallowed instead
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: state_nx = accept ? (ln_be == BE_FULL ? DRAIN : HOLD) : EMPTY;
      HOLD:  state_nx = (accept ? (out_be | ln_be) == BE_FULL : (in_valid && !same && !ln_mis) || timeout) || flush ? DRAIN : HOLD;
      DRAIN: state_nx = out_ready ? EMPTY : DRAIN;
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state <= EMPTY;
      out_addr <= '0;
      out_data <= '0;
      out_be <= '0;
      misalign_err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      misalign_err <= in_valid && in_ready && ln_mis;
      if (accept) begin
        out_addr <= in_word;
        out_data <= state == EMPTY ? ln_data : (out_data & ~mask) | (ln_data & mask);
        out_be <= state == EMPTY ? ln_be : out_be | ln_be;
        cnt <= '0;
      end else if (state == HOLD && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
